hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the enable and clear inputs of the PC and the IF/ID register (IF_ID_en, IF_ID_clr, int_clr), plus the ID/EX bubble clear.
- Detects load-use and branch-in-D data hazards combinationally.
- Tracks the multi-cycle multiply/divide unit with a busy counter.
- Sequences a two-state interrupt flush FSM.

---
 rtl/hazard_stall_ctrl_pkg.sv | 25 ++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 47 ++++
 rtl/hazard_stall_ctrl.sv | 96 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard/stall controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // True when an enabled producer writes a non-zero register that the consumer reads.
    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] src,
                                     input logic       en);
        return en && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Tracks how long the multiply/divide unit still owns HI/LO after an issue from E.
// Latency: counter loads on the edge after issue; md_busy is combinational with md_start.
// Backpressure: none; a new start while busy simply reloads the count.
module hazard_stall_ctrl_md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic inhibit,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load on issue (unless the issuing op is being flushed), otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start && !inhibit) begin
            cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register; an interrupt flush leaves it alone so an in-flight op completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The issuing cycle already counts as busy so a dependent md op right behind it stalls.
    assign md_busy = (cnt_q != '0) | md_start;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use / branch-in-D / HI-LO hazard stalls and interrupt flush.
// Latency: hazard outputs combinational same cycle; flush one cycle after int_req seen in RUN.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; flush overrides any stall.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       use_rs_d,
    input  logic       use_rt_d,
    input  logic       branch_d,
    input  logic       md_use_d,
    input  logic       eret_d,
    input  logic [4:0] wr_e,
    input  logic       regwrite_e,
    input  logic       load_e,
    input  logic [4:0] wr_m,
    input  logic       load_m,
    input  logic       md_start_e,
    input  logic       md_is_div_e,
    input  logic       int_req,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_clr,
    output logic       id_ex_clr,
    output logic       int_clr,
    output logic       exc_pc_sel,
    output logic       md_busy
);

    state_e state_q;
    state_e state_d;
    logic   stall_ld;
    logic   stall_br;
    logic   stall_md;
    logic   stall;

    hazard_stall_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start_e),
        .md_is_div (md_is_div_e),
        .inhibit   (int_clr),
        .md_busy   (md_busy)
    );

    // Hazard detection: loads in E cannot forward to E; branches compare in D, so they
    // also wait on any ALU result in E and any load result still in M.
    always_comb begin
        stall_ld = load_e && (reg_hit(wr_e, rs_d, use_rs_d) || reg_hit(wr_e, rt_d, use_rt_d));
        stall_br = branch_d && (reg_hit(wr_e, rs_d, regwrite_e) || reg_hit(wr_e, rt_d, regwrite_e) ||
                                reg_hit(wr_m, rs_d, load_m)     || reg_hit(wr_m, rt_d, load_m));
        stall_md = md_use_d && md_busy;
        stall    = stall_ld | stall_br | stall_md;
    end

    // Next state: a one-cycle FLUSH per accepted request; requests during FLUSH are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (int_req) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode straight from the registered state; the flush wins over any stall.
    always_comb begin
        int_clr    = (state_q == FLUSH);
        exc_pc_sel = (state_q == FLUSH);
        pc_en      = int_clr | !stall;
        if_id_en   = int_clr | !stall;
        id_ex_clr  = !int_clr && stall;
        if_id_clr  = !int_clr && eret_d && !stall;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, wr_e, wr_m;
    logic       use_rs_d, use_rt_d, branch_d, md_use_d, eret_d;
    logic       regwrite_e, load_e, load_m, md_start_e, md_is_div_e, int_req;
    logic       pc_en, if_id_en, if_id_clr, id_ex_clr, int_clr, exc_pc_sel, md_busy;

    int checks = 0;
    int errors = 0;

    // Output vector order: pc_en, if_id_en, if_id_clr, id_ex_clr, int_clr, exc_pc_sel, md_busy
    logic [6:0] outs;
    assign outs = {pc_en, if_id_en, if_id_clr, id_ex_clr, int_clr, exc_pc_sel, md_busy};

    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_BUSY  = 7'b1100001;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_STBSY = 7'b0001001;
    localparam logic [6:0] O_FLUSH = 7'b1100110;
    localparam logic [6:0] O_FLBSY = 7'b1100111;
    localparam logic [6:0] O_ERET  = 7'b1110000;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .branch_d(branch_d), .md_use_d(md_use_d), .eret_d(eret_d),
        .wr_e(wr_e), .regwrite_e(regwrite_e), .load_e(load_e),
        .wr_m(wr_m), .load_m(load_m),
        .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .int_req(int_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
        .int_clr(int_clr), .exc_pc_sel(exc_pc_sel), .md_busy(md_busy)
    );

    task automatic clear_inputs();
        reset = 1'b0; rs_d = '0; rt_d = '0; wr_e = '0; wr_m = '0;
        use_rs_d = 1'b0; use_rt_d = 1'b0; branch_d = 1'b0; md_use_d = 1'b0; eret_d = 1'b0;
        regwrite_e = 1'b0; load_e = 1'b0; load_m = 1'b0;
        md_start_e = 1'b0; md_is_div_e = 1'b0; int_req = 1'b0;
    endtask

    // Start a new cycle: inputs change just after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        next_cycle(); reset = 1'b1;
        next_cycle(); #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL reset_outputs got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_load_use();
        next_cycle(); load_e = 1'b1; wr_e = 5'd8; rs_d = 5'd8; use_rs_d = 1'b1; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ld_use_rs got %b want %b", outs, O_STALL); end
        next_cycle(); #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL ld_use_release got %b want %b", outs, O_RUN); end
        next_cycle(); load_e = 1'b1; wr_e = 5'd0; rs_d = 5'd0; use_rs_d = 1'b1; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL ld_use_r0 got %b want %b", outs, O_RUN); end
        next_cycle(); load_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9; use_rt_d = 1'b1; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ld_use_rt got %b want %b", outs, O_STALL); end
        next_cycle(); load_e = 1'b1; wr_e = 5'd9; rt_d = 5'd9; use_rt_d = 1'b0; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL ld_no_use got %b want %b", outs, O_RUN); end
        next_cycle(); regwrite_e = 1'b1; wr_e = 5'd9; rs_d = 5'd9; use_rs_d = 1'b1; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL alu_forward got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_branch();
        next_cycle(); branch_d = 1'b1; regwrite_e = 1'b1; wr_e = 5'd3; rt_d = 5'd3; rs_d = 5'd5; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL br_alu_e got %b want %b", outs, O_STALL); end
        next_cycle(); branch_d = 1'b1; load_m = 1'b1; wr_m = 5'd3; rt_d = 5'd3; rs_d = 5'd5; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL br_load_m got %b want %b", outs, O_STALL); end
        next_cycle(); branch_d = 1'b1; rt_d = 5'd3; rs_d = 5'd5; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL br_clear got %b want %b", outs, O_RUN); end
        next_cycle(); branch_d = 1'b1; regwrite_e = 1'b1; wr_e = 5'd0; rs_d = 5'd0; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL br_r0 got %b want %b", outs, O_RUN); end
        next_cycle(); branch_d = 1'b1; load_m = 1'b1; wr_m = 5'd12; rs_d = 5'd12; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL br_load_m_rs got %b want %b", outs, O_STALL); end
        next_cycle(); branch_d = 1'b0; regwrite_e = 1'b1; load_m = 1'b1; wr_e = 5'd7; wr_m = 5'd7; rs_d = 5'd7; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL nonbranch_no_stall got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_div_mflo();
        for (int c = 0; c <= 11; c++) begin
            next_cycle(); md_use_d = 1'b1;
            if (c == 0) begin md_start_e = 1'b1; md_is_div_e = 1'b1; end
            #1;
            checks++;
            if (outs !== ((c <= 10) ? O_STBSY : O_RUN)) begin
                errors++; $display("FAIL div_cycle%0d got %b want %b", c, outs, (c <= 10) ? O_STBSY : O_RUN);
            end
        end
    endtask

    task automatic test_mult_restart();
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c == 0 || c == 2) md_start_e = 1'b1;
            #1;
            checks++;
            if (outs !== ((c <= 7) ? O_BUSY : O_RUN)) begin
                errors++; $display("FAIL mult_cycle%0d got %b want %b", c, outs, (c <= 7) ? O_BUSY : O_RUN);
            end
        end
    endtask

    task automatic test_interrupt();
        // Interrupt arriving during a load-use stall; an md issue during the flush is dropped.
        next_cycle(); load_e = 1'b1; wr_e = 5'd8; rs_d = 5'd8; use_rs_d = 1'b1; int_req = 1'b1; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL int_c0 got %b want %b", outs, O_STALL); end
        next_cycle(); load_e = 1'b1; wr_e = 5'd8; rs_d = 5'd8; use_rs_d = 1'b1; int_req = 1'b1; md_start_e = 1'b1; #1;
        checks++; if (outs !== O_FLBSY) begin errors++; $display("FAIL int_flush got %b want %b", outs, O_FLBSY); end
        next_cycle(); load_e = 1'b1; wr_e = 5'd8; rs_d = 5'd8; use_rs_d = 1'b1; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL int_back_run got %b want %b", outs, O_STALL); end
        // Held request: RUN -> FLUSH -> RUN (ignored in FLUSH) -> FLUSH again.
        next_cycle(); int_req = 1'b1; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL int_held_c0 got %b want %b", outs, O_RUN); end
        next_cycle(); int_req = 1'b1; #1;
        checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL int_held_c1 got %b want %b", outs, O_FLUSH); end
        next_cycle(); int_req = 1'b1; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL int_held_c2 got %b want %b", outs, O_RUN); end
        next_cycle(); #1;
        checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL int_held_c3 got %b want %b", outs, O_FLUSH); end
        next_cycle(); #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL int_held_c4 got %b want %b", outs, O_RUN); end
        // Flush leaves an in-flight mult running.
        next_cycle(); md_start_e = 1'b1; #1;
        next_cycle(); int_req = 1'b1; #1;
        checks++; if (outs !== O_BUSY) begin errors++; $display("FAIL int_md_c1 got %b want %b", outs, O_BUSY); end
        next_cycle(); #1;
        checks++; if (outs !== O_FLBSY) begin errors++; $display("FAIL int_md_flush got %b want %b", outs, O_FLBSY); end
        next_cycle(); md_use_d = 1'b1; #1;
        checks++; if (outs !== O_STBSY) begin errors++; $display("FAIL int_md_after got %b want %b", outs, O_STBSY); end
        for (int c = 0; c < 4; c++) next_cycle();
    endtask

    task automatic test_eret();
        next_cycle(); eret_d = 1'b1; #1;
        checks++; if (outs !== O_ERET) begin errors++; $display("FAIL eret_squash got %b want %b", outs, O_ERET); end
        next_cycle(); eret_d = 1'b1; load_e = 1'b1; wr_e = 5'd4; rs_d = 5'd4; use_rs_d = 1'b1; #1;
        checks++; if (outs !== O_STALL) begin errors++; $display("FAIL eret_stalled got %b want %b", outs, O_STALL); end
        next_cycle(); #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL eret_done got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_reset_mid_op();
        next_cycle(); md_start_e = 1'b1; md_is_div_e = 1'b1; #1;
        next_cycle(); md_use_d = 1'b1; #1;
        checks++; if (outs !== O_STBSY) begin errors++; $display("FAIL rst_div_busy got %b want %b", outs, O_STBSY); end
        next_cycle(); reset = 1'b1; #1;
        next_cycle(); md_use_d = 1'b1; #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rst_div_cleared got %b want %b", outs, O_RUN); end
        next_cycle(); int_req = 1'b1; #1;
        next_cycle(); reset = 1'b1; int_req = 1'b1; #1;
        checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL rst_flush_pre got %b want %b", outs, O_FLUSH); end
        next_cycle(); #1;
        checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rst_flush_run got %b want %b", outs, O_RUN); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_div_mflo();
        test_mult_restart();
        test_interrupt();
        test_eret();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
